bidir_pin_xfer: RTL and testbench

- Half-duplex transfer engine for a single bidirectional test pad.
- Generates the I (drive value) and T (tristate) signals for the pad's BB primitive, and consumes its O (pad readback).
- One transaction: shift out a WIDTH-bit command with the pad driven, release the pad for a turnaround gap, then shift in a WIDTH-bit response.
- Sits directly upstream of the BB instance. Replaces hand-built state-pattern drive logic for pad bring-up and bench tests.

---
 rtl/bidir_pin_xfer.sv | 115 +++++++++++
 tb/tb_bidir_pin_xfer.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/bidir_pin_xfer.sv
// Half-duplex command/response engine for one bidirectional pad: drives WIDTH bits MSB-first,
// releases the pad for a turnaround gap, then samples WIDTH bits back through a 2-flop synchroniser.
module bidir_pin_xfer #(
    parameter int WIDTH             = 8,
    parameter int CLOCKS_PER_BIT    = 12,
    parameter int TURNAROUND_CLOCKS = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rx_data,
    output logic             pad_i,
    output logic             pad_t,
    input  logic             pad_o
);

    localparam int CW = $clog2(CLOCKS_PER_BIT);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int TW = $clog2(TURNAROUND_CLOCKS + 1);

    localparam logic [CW-1:0] CYC_LAST   = CW'(CLOCKS_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_SAMPLE = CW'(CLOCKS_PER_BIT / 2);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WIDTH - 1);
    localparam logic [TW-1:0] TURN_LAST  = TW'(TURNAROUND_CLOCKS - 1);

    typedef enum logic [1:0] {IDLE, TX, TURN, RX} state_t;

    state_t           state, next_state;
    logic [CW-1:0]    cyc_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [TW-1:0]    turn_cnt;
    logic [WIDTH-1:0] tx_shreg;
    logic [WIDTH-1:0] rx_shreg;
    logic [1:0]       sync_q;
    logic             bit_end;
    logic             last_bit;

    assign bit_end  = (cyc_cnt == CYC_LAST);
    assign last_bit = (bit_cnt == BIT_LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = TX;
            TX:      if (bit_end && last_bit) next_state = TURN;
            TURN:    if (turn_cnt == TURN_LAST) next_state = RX;
            RX:      if (bit_end && last_bit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // The pad is only ever driven while in TX; every other state leaves it released with I parked high.
    always_comb begin
        busy  = (state != IDLE);
        pad_t = 1'b1;
        pad_i = 1'b1;
        if (state == TX) begin
            pad_t = 1'b0;
            pad_i = tx_shreg[WIDTH-1];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt  <= '0;
            bit_cnt  <= '0;
            turn_cnt <= '0;
            tx_shreg <= '0;
            rx_shreg <= '0;
            sync_q   <= 2'b11;
            done     <= 1'b0;
            rx_data  <= '0;
        end else begin
            done   <= 1'b0;
            sync_q <= {sync_q[0], pad_o};
            unique case (state)
                IDLE: begin
                    if (start) begin
                        tx_shreg <= tx_data;
                        cyc_cnt  <= '0;
                        bit_cnt  <= '0;
                    end
                end
                TX, RX: begin
                    if (bit_end) begin
                        cyc_cnt <= '0;
                        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                    if (state == TX && bit_end)
                        tx_shreg <= tx_shreg << 1;
                    // Mid-bit sample; the last sample lands well before the final cycle, so the word is complete at exit.
                    if (state == RX && cyc_cnt == CYC_SAMPLE)
                        rx_shreg <= {rx_shreg[WIDTH-2:0], sync_q[1]};
                    if (state == RX && bit_end && last_bit) begin
                        done    <= 1'b1;
                        rx_data <= rx_shreg;
                    end
                end
                TURN: turn_cnt <= (turn_cnt == TURN_LAST) ? '0 : turn_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bidir_pin_xfer.sv
// Directed bench for bidir_pin_xfer (WIDTH=8, CPB=4, TC=2): a cycle model checks the pad every cycle,
// and a done-queue scoreboard checks each received word and its completion cycle.
module tb_bidir_pin_xfer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;
    logic [7:0] rx_data;
    logic       pad_i;
    logic       pad_t;
    logic       pad_o;

    bidir_pin_xfer #(
        .WIDTH(8),
        .CLOCKS_PER_BIT(4),
        .TURNAROUND_CLOCKS(2)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .tx_data(tx_data),
        .busy   (busy),
        .done   (done),
        .rx_data(rx_data),
        .pad_i  (pad_i),
        .pad_t  (pad_t),
        .pad_o  (pad_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] word;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         cur_vld = 1'b0;
    int         cur_c0 = 0;
    logic [7:0] cur_word = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle model: TX window is cycles c0+1..c0+32, busy window c0+1..c0+66.
    always @(negedge clock) begin
        bit in_tx;
        bit in_busy;
        int off;
        in_tx   = cur_vld && (cyc >= cur_c0 + 1) && (cyc <= cur_c0 + 32);
        in_busy = cur_vld && (cyc >= cur_c0 + 1) && (cyc <= cur_c0 + 66);
        off     = (cyc - cur_c0 - 1) / 4;
        chk("pad_t", {31'b0, pad_t}, {31'b0, !in_tx});
        chk("pad_i", {31'b0, pad_i}, in_tx ? {31'b0, cur_word[7-off]} : 32'd1);
        chk("busy", {31'b0, busy}, {31'b0, in_busy});
    end

    always @(negedge clock) begin
        exp_t e;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rx_data", {24'b0, rx_data}, {24'b0, e.word});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_at_done", {31'b0, busy}, 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Called at posedge+1 of the cycle in which start is to be accepted; returns in the done cycle.
    task automatic xfer(input logic [7:0] tx, input logic [7:0] rxw, input int ign_at, input int rst_at);
        exp_t e;
        int   c0;
        c0       = cyc;
        start    = 1'b1;
        tx_data  = tx;
        cur_c0   = c0;
        cur_word = tx;
        cur_vld  = 1'b1;
        if (rst_at == 0) begin
            e.word = rxw;
            e.cyc  = c0 + 67;
            sb.push_back(e);
        end
        for (int k = 1; k <= 66; k++) begin
            @(posedge clock);
            #1;
            start   = (k == ign_at);
            tx_data = ~tx;
            pad_o   = (k >= 35) ? rxw[7-((k-35)/4)] : 1'b1;
            if (k == rst_at) begin
                #1;
                reset   = 1'b1;
                cur_vld = 1'b0;
                pad_o   = 1'b1;
                #1;
                chk("rst_busy", {31'b0, busy}, 32'd0);
                chk("rst_pad_t", {31'b0, pad_t}, 32'd1);
                chk("rst_pad_i", {31'b0, pad_i}, 32'd1);
                chk("rst_rx_data", {24'b0, rx_data}, 32'd0);
                @(posedge clock);
                #1;
                reset = 1'b0;
                return;
            end
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        pad_o = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset   = 1'b1;
        start   = 1'b0;
        tx_data = 8'h00;
        pad_o   = 1'b1;
        @(posedge clock);
        #1;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_rx_data", {24'b0, rx_data}, 32'd0);
        chk("reset_pad_t", {31'b0, pad_t}, 32'd1);
        chk("reset_pad_i", {31'b0, pad_i}, 32'd1);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(2);

        xfer(8'hA5, 8'h3C, 0, 0);
        idle(3);
        chk("rx_hold", {24'b0, rx_data}, 32'h3C);

        xfer(8'hA5, 8'h96, 10, 0);
        idle(2);

        xfer(8'hA5, 8'h5A, 0, 20);
        idle(2);
        chk("post_rst_rx_data", {24'b0, rx_data}, 32'd0);
        xfer(8'hA5, 8'h5A, 0, 0);
        idle(2);

        xfer(8'h00, 8'hFF, 0, 0);
        xfer(8'hFF, 8'h69, 0, 0);
        xfer(8'h81, 8'h00, 0, 0);
        idle(4);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
